// File: rtl/irq_sequencer.sv
// irq_sequencer: walks the CPU through the RESET / NMI / IRQ / BRK entry.
// It pushes PCH, PCL and P onto the stack, then fetches the vector into the PC.
// Optional feature macro: NMI_HIJACK_EN. When it is defined, an NMI that becomes
// pending during an IRQ/BRK entry takes over the vector fetch.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an instruction boundary with a pending source
// S1    | dummy stack read; also the state held while rst is low
// S2    | push PCH (RESET: read only, SP still decremented)
// S3    | push PCL (RESET: read only, SP still decremented)
// S4    | push P with B = (kind == BRK) (RESET: read only, SP decremented)
// S5    | read vector low byte into PCL
// S6    | read vector high byte into PCH, set I, done pulse
module irq_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RST    = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        boundary,
    input  logic        brk,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic [7:0]  sp,
    output logic        busy,
    output logic [15:0] addr,
    output logic        rw,
    output logic [1:0]  push_sel,
    output logic        push_b,
    output logic        sp_dec,
    output logic        ld_pcl,
    output logic        ld_pch,
    output logic        set_i,
    output logic [1:0]  kind,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, S6} state_t;

    localparam logic [1:0] K_RESET = 2'd0;
    localparam logic [1:0] K_NMI   = 2'd1;
    localparam logic [1:0] K_IRQ   = 2'd2;
    localparam logic [1:0] K_BRK   = 2'd3;

    state_t      state, state_nx;
    logic        run;
    logic [1:0]  kind_q;
    logic [15:0] vec_q;
    logic [15:0] vec_sel;
    logic        nmi_pend, nmi_prev;
    logic        accept;
    logic [1:0]  win;
    logic        enter_s5;
    logic        hijack;

    assign enter_s5 = run && !stall && (state == S4);
    assign kind     = kind_q;

`ifdef NMI_HIJACK_EN
    assign hijack = nmi_pend && (kind_q == K_IRQ || kind_q == K_BRK);
`else
    assign hijack = 1'b0;
`endif

    // Arbitration at an unstalled boundary: NMI > BRK > unmasked IRQ.
    always_comb begin
        accept = 1'b0;
        win    = K_IRQ;
        if (state == IDLE && boundary && !stall) begin
            if (nmi_pend) begin
                accept = 1'b1;
                win    = K_NMI;
            end else if (brk) begin
                accept = 1'b1;
                win    = K_BRK;
            end else if (!irq_n && !i_flag) begin
                accept = 1'b1;
                win    = K_IRQ;
            end
        end
    end

    // Vector chosen as the sequence enters S5.
    always_comb begin
        case (kind_q)
            K_NMI:   vec_sel = VEC_NMI;
            K_RESET: vec_sel = VEC_RST;
            default: vec_sel = VEC_IRQ;
        endcase
        if (hijack) vec_sel = VEC_NMI;
    end

    // State register. The first edge after reset release is spent in S1,
    // so the reset entry has the same six-cycle length as an interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S1;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    // Next-state logic; stall freezes the sequence in place.
    always_comb begin
        state_nx = state;
        if (!run) begin
            state_nx = S1;
        end else if (!stall) begin
            case (state)
                IDLE:    state_nx = accept ? S1 : IDLE;
                S1:      state_nx = S2;
                S2:      state_nx = S3;
                S3:      state_nx = S4;
                S4:      state_nx = S5;
                S5:      state_nx = S6;
                S6:      state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Source kind, latched vector and NMI edge detection. nmi_prev samples
    // even while stalled. A fresh edge wins over a clear in the same cycle,
    // so that NMI is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_q   <= K_RESET;
            vec_q    <= VEC_RST;
            nmi_pend <= 1'b0;
            nmi_prev <= 1'b1;
        end else begin
            nmi_prev <= nmi_n;
            if (accept)
                kind_q <= win;
            else if (enter_s5 && hijack)
                kind_q <= K_NMI;
            if (enter_s5)
                vec_q <= vec_sel;
            if (nmi_prev && !nmi_n)
                nmi_pend <= 1'b1;
            else if (enter_s5 && (kind_q == K_NMI || hijack))
                nmi_pend <= 1'b0;
        end
    end

    // Bus and register-file strobes decoded from the current state.
    always_comb begin
        busy     = (state != IDLE);
        rw       = 1'b1;
        addr     = {STACK_PAGE, sp};
        push_sel = 2'd0;
        push_b   = 1'b0;
        sp_dec   = 1'b0;
        ld_pcl   = 1'b0;
        ld_pch   = 1'b0;
        set_i    = 1'b0;
        done     = 1'b0;
        case (state)
            S2, S3, S4: begin
                sp_dec = 1'b1;
                if (kind_q != K_RESET) begin
                    rw       = 1'b0;
                    push_sel = (state == S2) ? 2'd1 : (state == S3) ? 2'd2 : 2'd3;
                    push_b   = (state == S4) && (kind_q == K_BRK);
                end
            end
            S5: begin
                addr   = vec_q;
                ld_pcl = 1'b1;
            end
            S6: begin
                addr   = vec_q + 16'd1;
                ld_pch = 1'b1;
                set_i  = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
        if (stall) begin
            rw       = 1'b1;
            push_sel = 2'd0;
            sp_dec   = 1'b0;
            ld_pcl   = 1'b0;
            ld_pch   = 1'b0;
            set_i    = 1'b0;
            done     = 1'b0;
        end
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Sequences the CPU register file and bus through the 6502 interrupt/reset entry: RESET, NMI, IRQ and BRK.
- Arbitrates between pending interrupt sources at instruction boundaries.
- Drives the stack pushes of PCH, PCL and P, then loads PCL/PCH from the selected vector.
- Sits beside the instruction decoder; its strobes feed the register file's store/stack/PC selects.

Parameters:
- STACK_PAGE, 8'h01, high address byte for stack accesses.
- VEC_NMI, 16'hFFFA, NMI vector low address.
- VEC_RST, 16'hFFFC, RESET vector low address.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freezes sequencer state (RDY low).
- boundary  in  1  CPU is at an opcode-fetch boundary.
- brk  in  1  decoded BRK opcode at the boundary.
- nmi_n  in  1  NMI pin, active low, edge-triggered.
- irq_n  in  1  IRQ pin, active low, level.
- i_flag  in  1  interrupt-disable flag from the status register.
- sp  in  8  current stack pointer.
- busy  out  1  sequence in progress; decoder must idle.
- addr  out  16  bus address.
- rw  out  1  1 = read, 0 = write.
- push_sel  out  2  0 none, 1 PCH, 2 PCL, 3 P onto the data bus.
- push_b  out  1  B bit value for the pushed P.
- sp_dec  out  1  decrement SP this cycle.
- ld_pcl  out  1  store data bus into PCL.
- ld_pch  out  1  store data bus into PCH.
- set_i  out  1  set I flag.
- kind  out  2  0 RESET, 1 NMI, 2 IRQ, 3 BRK.
- done  out  1  one-cycle pulse on the final cycle.

Behaviour:
- States: IDLE, S1..S6. rst low forces S1 with kind=RESET, nmi_pend=0, nmi_prev=1. Outputs while in reset: busy=1, rw=1, addr={STACK_PAGE,sp}, all strobes 0, done=0.
- After rst deasserts, the reset sequence runs automatically: S1 at the first rising edge, then S2 and onward.
- NMI detect: nmi_prev samples nmi_n every cycle, including while stalled. A 1→0 transition sets nmi_pend. nmi_pend clears when the S5 vector is latched for kind NMI.
- Accept (IDLE, boundary=1, stall=0). Priority is NMI (nmi_pend) > BRK (brk) > IRQ (irq_n=0 and i_flag=0). The winner is latched into kind and the next state is S1. With no winner, stay IDLE.
- S1: dummy read, addr={STACK_PAGE,sp}.
- S2: addr={STACK_PAGE,sp}, push_sel=1, sp_dec=1.
- S3: addr={STACK_PAGE,sp}, push_sel=2, sp_dec=1.
- S4: addr={STACK_PAGE,sp}, push_sel=3, push_b=(kind==BRK), sp_dec=1.
- S2–S4 write rule: rw=0, except rw=1 and push_sel=0 for RESET. RESET still asserts sp_dec, so SP decreases by 3 total.
- Vector selection happens on entry to S5 (see Optional Feature). The selected vector is held in vec.
- S5: addr=vec, rw=1, ld_pcl=1.
- S6: addr=vec+1, rw=1, ld_pch=1, set_i=1, done=1. Next state is IDLE; busy drops the following cycle.
- Latency: 6 busy cycles from acceptance to done, plus one per stall cycle.
- stall=1: state holds, addr holds, and rw, push_sel, sp_dec, ld_*, set_i and done are forced inactive (rw=1). Interrupts are not accepted in IDLE while stalled.
- Stack addressing uses sp as presented each cycle; the register file applies sp_dec at the clock edge. SP wraps 8'h00→8'hFF (page wrap only).
- An nmi_n edge during a sequence sets nmi_pend. It is serviced at the next boundary unless hijacked.
- Reset mid-sequence aborts immediately to RESET S1.
- IRQ deasserting after acceptance does not abort.
- BRK and IRQ together: BRK wins, and the IRQ is re-evaluated at the next boundary.

Optional Feature:
- Macro: NMI_HIJACK_EN.
- Defined: on entry to S5, if kind is IRQ or BRK and nmi_pend=1, vec=VEC_NMI, kind becomes NMI and nmi_pend clears. push_b retains the original BRK value, since it was already pushed.
- Undefined: vec follows the kind latched at acceptance.

Test Plan:
- Power-up: rst=0 for 2 cycles, sp=8'hFD, then release. Expect S5 addr=16'hFFFC and S6 addr=16'hFFFD, rw=1 throughout, three sp_dec pulses, push_sel=0, done in the 6th cycle after release.
- IRQ: irq_n=0, i_flag=0, boundary=1, sp=8'hFF. Expect writes at 16'h01FF/01FE/01FD with push_sel 1/2/3, push_b=0, then vector 16'hFFFE/16'hFFFF, set_i in S6.
- IRQ masked: i_flag=1, irq_n=0, boundary=1. Expect busy stays 0 and no strobes.
- NMI vs BRK: nmi_n falls, then boundary=1 with brk=1. Expect kind=NMI, vector 16'hFFFA; at the next boundary, BRK is accepted with push_b=1.
- Stall: assert stall for 3 cycles during S3. Expect addr held, no sp_dec while stalled, done 9 cycles after acceptance.
- Hijack (NMI_HIJACK_EN defined): nmi_n falls during S3 of a BRK. Expect S5 addr=16'hFFFA, push_b=1 in S4, nmi_pend cleared. Without the macro: addr=16'hFFFE, and NMI serviced next boundary.
